stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count_en rate in Hz while running.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-level cycles required to accept a key change.
REQ-004 SHALL have port CLOCK_50  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port KEY  input  4  board push-buttons, active-low, asynchronous; KEY[0] start/pause, KEY[1] clear, KEY[2] lap, KEY[3] unused.
REQ-007 SHALL have port count_en  output  1  one-cycle increment strobe for the time counter.
REQ-008 SHALL have port clear  output  1  one-cycle strobe zeroing the time counter.
REQ-009 SHALL have port running  output  1  high while state is RUN.
REQ-010 SHALL have port state  output  2  current state: IDLE=0, RUN=1, PAUSE=2.
REQ-011 SHALL have port lap_hold  output  1  high while the display is frozen.

Function
REQ-012 SHALL pass each KEY bit through a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-013 SHALL emit a one-cycle press event on each debounced 1->0 transition; releases produce no event.
REQ-014 SHALL reject pulses shorter than DEBOUNCE_CYCLES; a key held low produces exactly one event.
REQ-015 SHALL implement FSM: KEY[0] event IDLE->RUN, RUN->PAUSE, PAUSE->RUN; KEY[1] event from any state ->IDLE.
REQ-016 SHALL update state on the clock edge following the press event.
REQ-017 SHALL give KEY[1] priority when KEY[0] and KEY[1] events coincide.
REQ-018 SHALL assert clear for exactly one cycle on every KEY[1] event, including from IDLE.
REQ-019 SHALL use DIV = CLK_HZ/TICK_HZ and a divider counting 0..DIV-1, width $clog2(DIV).
REQ-020 SHALL advance the divider only in RUN, hold it in PAUSE, zero it in IDLE and on clear; wrap DIV-1->0.
REQ-021 SHALL register count_en: high one cycle after each divider wrap in RUN; first strobe DIV cycles after RUN entry from IDLE.
REQ-022 SHALL never assert count_en and clear in the same cycle.
REQ-023 SHALL treat DIV<2 or CLK_HZ not a multiple of TICK_HZ as an elaboration error.

Reset
REQ-024 SHALL, while reset is high at a clock edge, force state IDLE, divider and debounce counters 0, synchronizer and debounced levels 1 (released), all outputs 0.
REQ-025 SHALL abort any operation on reset mid-RUN/PAUSE; a key held low through reset release yields one press after DEBOUNCE_CYCLES.

Configuration
REQ-026 SHALL, with STOPWATCH_LAP_EN defined, toggle lap_hold on each KEY[2] event in RUN or PAUSE, ignore it in IDLE, clear lap_hold on entering IDLE; count_en unaffected by lap_hold.
REQ-027 SHALL, without STOPWATCH_LAP_EN, tie lap_hold to 0, ignore KEY[2], and instantiate no KEY[2] debouncer.

Structure
REQ-028 SHALL place the state typedef (IDLE/RUN/PAUSE encodings) and default CLK_HZ/TICK_HZ constants in shared package stopwatch_pkg.
REQ-029 SHALL implement synchronizer+debouncer+edge detect as sub-module key_debounce, one instance per used key.

Verification (CLK_HZ=1000, TICK_HZ=100, DEBOUNCE_CYCLES=4)
REQ-030 SHALL cover: KEY[0] low 10 cycles after reset -> single event, state 0->1, count_en every 10 cycles, first 10 cycles after RUN entry.
REQ-031 SHALL cover: KEY[0] low 3 cycles -> no event, state stays IDLE.
REQ-032 SHALL cover: pause 6 cycles into a tick period, wait 50 cycles, resume -> no count_en during PAUSE, first strobe 4 cycles after resume.
REQ-033 SHALL cover: KEY[0] and KEY[1] events same cycle in RUN -> clear high one cycle, state 0, no further count_en.
REQ-034 SHALL cover: reset high one cycle mid-RUN -> next cycle state 0, all outputs 0, divider restarts from 0.
REQ-035 SHALL cover: KEY[2] events in RUN -> lap_hold 0->1->0 with count_en uninterrupted (macro on); lap_hold stays 0 (macro off).

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding and default clocking constants.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int unsigned DEF_CLK_HZ  = 50_000_000;
  localparam int unsigned DEF_TICK_HZ = 100;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer, level debouncer and press
// (debounced 1->0) edge detector. Key input is active-low.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // The counter tracks how many consecutive samples disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = level_q & ~level_d;
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced keys drive an IDLE/RUN/PAUSE FSM and a tick divider.
// Optional lap-hold display freeze is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ         = DEF_TICK_HZ,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] KEY,
  output logic       count_en,
  output logic       clear,
  output logic       running,
  output logic [1:0] state,
  output logic       lap_hold
);

  localparam int unsigned DIV     = CLK_HZ / ((TICK_HZ == 0) ? 1 : TICK_HZ);
  localparam int unsigned CLK_REM = CLK_HZ % ((TICK_HZ == 0) ? 1 : TICK_HZ);
  localparam int unsigned DW      = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

  if (TICK_HZ == 0 || DIV < 2 || CLK_REM != 0) begin : g_bad_cfg
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an exact integer of at least 2");
  end

  logic start_evt, clear_evt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .key_ni  (KEY[0]),
    .press_o (start_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .key_ni  (KEY[1]),
    .press_o (clear_evt)
  );

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          count_en_q, count_en_d;
  logic          clear_q, clear_d;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      count_en_q <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      count_en_q <= count_en_d;
      clear_q    <= clear_d;
    end
  end

  // Clear wins over start/pause when both keys fire together.
  always_comb begin
    state_d = state_q;
    if (clear_evt) begin
      state_d = IDLE;
    end else if (start_evt) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    div_d = div_q;
    if (clear_evt || state_q == IDLE) begin
      div_d = '0;
    end else if (state_q == RUN) begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    end
    // A wrap coinciding with a clear is dropped so the strobes never overlap.
    count_en_d = (state_q == RUN) && (div_q == DIV_MAX) && !clear_evt;
    clear_d    = clear_evt;
  end

  always_comb begin
    state    = state_q;
    running  = (state_q == RUN);
    count_en = count_en_q;
    clear    = clear_q;
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_evt;
  logic lap_q, lap_d;
  logic unused_keys;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .key_ni  (KEY[2]),
    .press_o (lap_evt)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lap_q <= 1'b0;
    end else begin
      lap_q <= lap_d;
    end
  end

  // IDLE is only entered through a clear event, so that is where the freeze is dropped.
  always_comb begin
    lap_d = lap_q;
    if (clear_evt) begin
      lap_d = 1'b0;
    end else if (lap_evt && state_q != IDLE) begin
      lap_d = ~lap_q;
    end
  end

  assign lap_hold    = lap_q;
  assign unused_keys = KEY[3];
`else
  logic [1:0] unused_keys;

  assign lap_hold    = 1'b0;
  assign unused_keys = KEY[3:2];
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=100, DEBOUNCE_CYCLES=4.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       count_en, clear, running, lap_hold;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(
    .CLK_HZ          (1000),
    .TICK_HZ         (100),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .KEY      (key),
    .count_en (count_en),
    .clear    (clear),
    .running  (running),
    .state    (state),
    .lap_hold (lap_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] key;
    int         cyc;
    int         st;
    int         en;
    int         clr;
    int         lap;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key = 4'hF;
    repeat (2) step();
    rst = 1'b0;
  endtask

  function automatic bit in_rng(input int n, input int lo, input int hi);
    return (n >= lo) && (n < hi);
  endfunction

  task automatic chk_all(input string tag, input int n, input int st, input int en,
                         input int clr, input int lap);
    chk($sformatf("%s n=%0d state", tag, n), 32'(state), 32'(st));
    chk($sformatf("%s n=%0d running", tag, n), 32'(running), 32'(st == 1));
    chk($sformatf("%s n=%0d count_en", tag, n), 32'(count_en), 32'(en));
    chk($sformatf("%s n=%0d clear", tag, n), 32'(clear), 32'(clr));
    chk($sformatf("%s n=%0d lap_hold", tag, n), 32'(lap_hold), 32'(lap));
  endtask

  initial begin
    int en_cnt, clr_cnt, st, en, clr, lap;

    rst = 1'b1;
    key = 4'hF;

    //          rst   key    cyc st en clr lap
    vecs[0]  = '{1'b1, 4'hF,  2, 0, 0, 0, 0};
    vecs[1]  = '{1'b0, 4'hF,  4, 0, 0, 0, 0};
    vecs[2]  = '{1'b0, 4'hE,  3, 0, 0, 0, 0};  // too short to pass the debouncer
    vecs[3]  = '{1'b0, 4'hF, 10, 0, 0, 0, 0};
    vecs[4]  = '{1'b0, 4'hD, 10, 0, 0, 1, 0};  // clear from IDLE still strobes
    vecs[5]  = '{1'b0, 4'hF, 10, 0, 0, 0, 0};
    vecs[6]  = '{1'b0, 4'hE, 10, 1, 0, 0, 0};
    vecs[7]  = '{1'b0, 4'hF, 30, 1, 3, 0, 0};
    vecs[8]  = '{1'b0, 4'hD, 10, 0, 0, 1, 0};  // clear lands on a wrap: tick suppressed
    vecs[9]  = '{1'b0, 4'hF, 20, 0, 0, 0, 0};
    vecs[10] = '{1'b0, 4'hE, 10, 1, 0, 0, 0};
    vecs[11] = '{1'b0, 4'hF, 10, 1, 1, 0, 0};
    vecs[12] = '{1'b0, 4'hE, 10, 2, 1, 0, 0};
    vecs[13] = '{1'b0, 4'hF, 50, 2, 0, 0, 0};
    vecs[14] = '{1'b0, 4'hE, 10, 1, 0, 0, 0};
    vecs[15] = '{1'b0, 4'hF, 10, 1, 1, 0, 0};

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst;
      key = vecs[i].key;
      en_cnt  = 0;
      clr_cnt = 0;
      repeat (vecs[i].cyc) begin
        step();
        en_cnt  += int'(count_en);
        clr_cnt += int'(clear);
      end
      chk($sformatf("seg%0d state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("seg%0d running", i), 32'(running), 32'(vecs[i].st == 1));
      chk($sformatf("seg%0d ticks", i), 32'(en_cnt), 32'(vecs[i].en));
      chk($sformatf("seg%0d clears", i), 32'(clr_cnt), 32'(vecs[i].clr));
      chk($sformatf("seg%0d lap_hold", i), 32'(lap_hold), 32'(vecs[i].lap));
    end

    // Start, exact tick spacing, pause with divider at 6, resume after 50+ cycles.
    do_reset();
    key = 4'hE;
    for (int n = 1; n <= 110; n++) begin
      step();
      st = (n < 7) ? 0 : (n < 33) ? 1 : (n < 90) ? 2 : 1;
      en = int'(n == 17 || n == 27 || n == 94 || n == 104);
      chk_all("pause", n, st, en, 0, 0);
      key    = 4'hF;
      key[0] = !(in_rng(n, 0, 10) || in_rng(n, 26, 36) || in_rng(n, 83, 93));
    end

    // Start and clear pressed together while running: clear wins, wrap suppressed.
    do_reset();
    key = 4'hE;
    for (int n = 1; n <= 60; n++) begin
      step();
      st  = (n >= 7 && n < 27) ? 1 : 0;
      en  = int'(n == 17);
      clr = int'(n == 27);
      chk_all("both", n, st, en, clr, 0);
      key = 4'hF;
      if (in_rng(n, 0, 10)) key[0] = 1'b0;
      if (in_rng(n, 20, 30)) key[1:0] = 2'b00;
    end

    // Reset pulse mid-RUN with KEY[0] held low through it: one press, divider from 0.
    do_reset();
    key = 4'hE;
    for (int n = 1; n <= 55; n++) begin
      step();
      st = (n < 7) ? 0 : (n < 23) ? 1 : (n < 30) ? 0 : 1;
      en = int'(n == 17 || n == 40 || n == 50);
      chk_all("rst", n, st, en, 0, 0);
      rst    = (n == 22);
      key    = 4'hF;
      key[0] = !(in_rng(n, 0, 10) || in_rng(n, 22, 42));
    end

    // Lap toggles in RUN, drops on clear, ignored in IDLE; ticks keep coming.
    do_reset();
    key = 4'hE;
    for (int n = 1; n <= 75; n++) begin
      step();
      st  = (n >= 7 && n < 59) ? 1 : 0;
      en  = int'(n == 17 || n == 27 || n == 37 || n == 47 || n == 57);
      clr = int'(n == 59);
      lap = int'(LAP_ON && (in_rng(n, 19, 39) || in_rng(n, 49, 59)));
      chk_all("lap", n, st, en, clr, lap);
      key    = 4'hF;
      key[0] = !in_rng(n, 0, 10);
      key[1] = !in_rng(n, 52, 57);
      key[2] = !(in_rng(n, 12, 17) || in_rng(n, 32, 37) || in_rng(n, 42, 47) ||
                 in_rng(n, 62, 67));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
